// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter sharing one UART transmitter between NREQ byte requesters.
//   A byte is accepted from one requester at a time and driven on tx_in with send
//   held high for SEND_HOLD cycles. The frame is then tracked through tx_done, and
//   a per-requester completion pulse (or a timeout pulse) is returned.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   req_valid    per-requester byte pending
//   req_data     byte of requester i at [8i+7:8i]
//   req_ready    one-cycle pulse, byte of requester i accepted
//   req_done     one-cycle pulse, frame of requester i completed
//   tx_in, send  byte and transmit request towards the transmitter
//   tx_done      transmitter frame-complete level
//   busy         high whenever the arbiter is not idle
//   err_timeout  one-cycle pulse when a frame is abandoned
//   grant_id     index of the current or last granted requester
module uart_tx_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned SEND_HOLD = 10418,
    parameter int unsigned TIMEOUT   = 131072
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         req_done,
    output logic [7:0]              tx_in,
    output logic                    send,
    input  logic                    tx_done,
    output logic                    busy,
    output logic                    err_timeout,
    output logic [$clog2(NREQ)-1:0] grant_id
);

    localparam int unsigned IdW   = $clog2(NREQ);
    localparam int unsigned HoldW = $clog2(SEND_HOLD + 1);
    localparam int unsigned TimeW = $clog2(TIMEOUT + 1);

    localparam logic [IdW-1:0]   IdLast   = IdW'(NREQ - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(SEND_HOLD - 1);
    localparam logic [TimeW-1:0] TimeLast = TimeW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWaitDone,
        StGap
    } state_e;

    state_e           state;
    logic [IdW-1:0]   rr_ptr;
    logic [HoldW-1:0] hold_cnt;
    logic [TimeW-1:0] timer;
    logic             tx_done_q;

    logic             tx_done_rise;
    logic [IdW-1:0]   next_ptr;
    logic             arb_found;
    logic [IdW-1:0]   arb_idx;
    logic [IdW-1:0]   cand;
    logic [7:0]       arb_byte;

    assign tx_done_rise = tx_done & ~tx_done_q;

    // The requester just served becomes lowest priority on the next arbitration.
    assign next_ptr = (grant_id == IdLast) ? '0 : grant_id + IdW'(1);

    // First valid requester searching upward from rr_ptr with wrap-around.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        arb_byte  = 8'h00;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IdW'((32'(rr_ptr) + k) % NREQ);
            if (!arb_found && req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (arb_idx == IdW'(k)) begin
                arb_byte = req_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            timer       <= '0;
            tx_done_q   <= 1'b0;
            req_ready   <= '0;
            req_done    <= '0;
            tx_in       <= 8'h00;
            send        <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            grant_id    <= '0;
        end else begin
            tx_done_q   <= tx_done;
            req_ready   <= '0;
            req_done    <= '0;
            err_timeout <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (arb_found) begin
                        grant_id  <= arb_idx;
                        tx_in     <= arb_byte;
                        req_ready <= NREQ'(1) << arb_idx;
                        send      <= 1'b1;
                        busy      <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= StSend;
                    end
                end

                // A tx_done rise here is deliberately ignored.
                StSend: begin
                    if (hold_cnt == HoldLast) begin
                        send  <= 1'b0;
                        timer <= '0;
                        state <= StWaitDone;
                    end else begin
                        hold_cnt <= hold_cnt + HoldW'(1);
                    end
                end

                StWaitDone: begin
                    if (tx_done_rise) begin
                        req_done <= NREQ'(1) << grant_id;
                        rr_ptr   <= next_ptr;
                        state    <= StGap;
                    end else if (timer == TimeLast) begin
                        err_timeout <= 1'b1;
                        rr_ptr      <= next_ptr;
                        state       <= StGap;
                    end else begin
                        timer <= timer + TimeW'(1);
                    end
                end

                // Let a still-high tx_done level drain so it cannot complete the next frame.
                StGap: begin
                    if (!tx_done_q) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter: reset values, round-robin order, fairness,
//   single request with a spurious tx_done during send, timeout, stale tx_done
//   level, and reset in the middle of a frame. A short SEND_HOLD keeps run time low.
module tb_uart_tx_arbiter;

    localparam int unsigned NReq     = 4;
    localparam int unsigned SendHold = 64;
    localparam int unsigned Timeout  = 1000;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  req_done;
    logic [7:0]  tx_in;
    logic        send;
    logic        tx_done;
    logic        busy;
    logic        err_timeout;
    logic [1:0]  grant_id;

    int n_cmp = 0;
    int n_mis = 0;

    int         mon_dones;
    int         mon_readies;
    int         mon_tos;
    logic [3:0] mon_dval;

    uart_tx_arbiter #(
        .NREQ      (NReq),
        .SEND_HOLD (SendHold),
        .TIMEOUT   (Timeout)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .req_done    (req_done),
        .tx_in       (tx_in),
        .send        (send),
        .tx_done     (tx_done),
        .busy        (busy),
        .err_timeout (err_timeout),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_clear();
        mon_dones   = 0;
        mon_readies = 0;
        mon_tos     = 0;
        mon_dval    = 4'b0000;
    endtask

    task automatic mon();
        if (req_done != 4'b0000) begin
            mon_dones++;
            mon_dval = req_done;
        end
        if (req_ready != 4'b0000) mon_readies++;
        if (err_timeout) mon_tos++;
    endtask

    // Wait for the grant of requester id, check the whole send phase, then
    // complete the frame with tx_done held high for done_len cycles.
    task automatic run_frame(input int id, input logic [7:0] byte_v, input logic [3:0] nv,
                             input int done_len, input bit spur);
        int          k;
        int          sent;
        int          bad_tx;
        logic [31:0] saved;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (req_ready == 4'b0000 && k < 20);
        check("req_ready", req_ready, 32'(1) << id);
        check("grant_id", grant_id, id);
        check("tx_in", tx_in, byte_v);
        check("send_on_grant", send, 1);
        check("busy_on_grant", busy, 1);
        // Inputs must be ignored while the frame is in flight.
        req_valid = nv;
        saved     = req_data;
        req_data  = ~req_data;
        sent      = 0;
        bad_tx    = 0;
        while (send === 1'b1 && sent < int'(SendHold) + 10) begin
            if (tx_in !== byte_v) bad_tx++;
            if (spur && sent == 10) tx_done = 1'b1;
            if (spur && sent == 14) tx_done = 1'b0;
            sent++;
            @(negedge clk);
        end
        check("send_len", sent, SendHold);
        check("tx_in_stable", bad_tx, 0);
        req_data = saved;
        mon_clear();
        repeat (4) begin
            @(negedge clk);
            mon();
        end
        tx_done = 1'b1;
        repeat (done_len) begin
            @(negedge clk);
            mon();
        end
        tx_done = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            mon();
            k++;
        end while (busy !== 1'b0 && k < 10);
        check("busy_idle", busy, 0);
        check("done_count", mon_dones, 1);
        check("done_id", mon_dval, 32'(1) << id);
        check("no_grant_in_gap", mon_readies, 0);
        check("no_timeout", mon_tos, 0);
    endtask

    initial begin
        int k;
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        tx_done   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_req_done", req_done, 0);
        check("rst_tx_in", tx_in, 8'h00);
        check("rst_send", send, 0);
        check("rst_busy", busy, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_grant_id", grant_id, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_grant", req_ready, 0);

        // Round robin with all four held, then fairness between 0 and 2.
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1111;
        run_frame(0, 8'h11, 4'b1111, 8, 0);
        run_frame(1, 8'h22, 4'b1111, 8, 0);
        run_frame(2, 8'h33, 4'b1111, 8, 0);
        run_frame(3, 8'h44, 4'b1111, 8, 0);
        run_frame(0, 8'h11, 4'b0101, 8, 0);
        run_frame(2, 8'h33, 4'b0101, 8, 0);
        run_frame(0, 8'h11, 4'b0000, 8, 0);

        // Single request, with a tx_done pulse during send that must be ignored.
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        run_frame(0, 8'hA5, 4'b0000, 8, 1);

        // Timeout with tx_done held low.
        req_data[15:8] = 8'hC3;
        req_valid      = 4'b0010;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (req_ready == 4'b0000 && k < 20);
        check("to_req_ready", req_ready, 4'b0010);
        check("to_tx_in", tx_in, 8'hC3);
        req_valid = 4'b0000;
        k = 0;
        while (send === 1'b1 && k < int'(SendHold) + 10) begin
            @(negedge clk);
            k++;
        end
        check("to_send_len", k, SendHold);
        mon_clear();
        k = 0;
        while (err_timeout !== 1'b1 && k < int'(Timeout) + 10) begin
            @(negedge clk);
            k++;
            if (req_done != 4'b0000) mon_dones++;
        end
        check("to_latency", k, Timeout);
        @(negedge clk);
        check("to_one_cycle", err_timeout, 0);
        k = 0;
        while (busy !== 1'b0 && k < 10) begin
            @(negedge clk);
            if (req_done != 4'b0000) mon_dones++;
            k++;
        end
        check("to_busy_idle", busy, 0);
        check("to_no_done", mon_dones, 0);

        // Stale tx_done level: req2 waits while tx_done stays high after frame of req3.
        req_data[31:16] = {8'h7E, 8'h99};
        req_valid       = 4'b1000;
        run_frame(3, 8'h7E, 4'b0100, 500, 0);
        run_frame(2, 8'h99, 4'b0000, 8, 0);

        // Reset in the middle of send; afterwards the pointer must be back at 0.
        req_data[15:8] = 8'h3C;
        req_valid      = 4'b0010;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (req_ready == 4'b0000 && k < 20);
        check("rs_req_ready", req_ready, 4'b0010);
        req_valid = 4'b0000;
        repeat (SendHold / 2) @(negedge clk);
        check("rs_send_before", send, 1);
        rst = 1'b1;
        #1;
        check("rs_send", send, 0);
        check("rs_busy", busy, 0);
        check("rs_grant_id", grant_id, 0);
        check("rs_tx_in", tx_in, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_clear();
        tx_done = 1'b1;
        repeat (5) begin
            @(negedge clk);
            mon();
        end
        tx_done = 1'b0;
        repeat (50) begin
            @(negedge clk);
            mon();
        end
        check("rs_no_done", mon_dones, 0);
        check("rs_no_grant", mon_readies, 0);
        check("rs_idle", busy, 0);
        req_valid = 4'b1100;
        run_frame(2, 8'h99, 4'b0000, 8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no completion expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
